// File: rtl/control_unit_hs.sv
// Multicycle RISC-V control FSM: fetch/decode/exec/mem/writeback with a mem_ack handshake, watchdog, halt/resume and instret.
// ALU op 3 cycles, load 4, store 3 at zero wait; each low mem_ack cycle in a memory state stalls one cycle; outputs decode state/inputs.
module control_unit_hs #(
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic                error,
  input  logic                mem_ack,
  input  logic                resume,
  output logic                pcUpdate,
  output logic                regWrite,
  output logic                memWrite,
  output logic                memRead,
  output logic                irWrite,
  output logic                halted,
  output logic                timeout,
  output logic [RETIRE_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] wcnt;
  logic             waiting;
  logic             wd_hit;
  logic             retire;

  always_comb begin
    waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    wd_hit  = (TIMEOUT != 0) && waiting && !mem_ack && (wcnt == CNT_LAST);
    nxt     = state;
    retire  = 1'b0;
    case (state)
      S_FETCH:  if (mem_ack) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD:  nxt = S_MEM_RD;
          OP_STORE: nxt = S_MEM_WR;
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_IMM, OP_OP: nxt = S_EXEC;
          default:  nxt = S_HALT;
        endcase
      end
      S_EXEC: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_MEM_RD: if (mem_ack) nxt = S_WB;
      S_WB: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ack) begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end
      end
      S_HALT:  if (resume) nxt = S_FETCH;
      default: nxt = S_HALT;
    endcase
    if (wd_hit) nxt = S_HALT;
    // A datapath fault overrides everything, including a completing retire.
    if (error) begin
      nxt    = S_HALT;
      retire = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      wcnt    <= '0;
      timeout <= 1'b0;
      instret <= '0;
    end else begin
      state <= nxt;
      // Counter only survives while parked in the same memory state without ack.
      if (waiting && !mem_ack && (nxt == state)) wcnt <= wcnt + CNT_W'(1);
      else                                       wcnt <= '0;
      if (!error) begin
        if (wd_hit)                           timeout <= 1'b1;
        else if ((state == S_HALT) && resume) timeout <= 1'b0;
      end
      if (retire) instret <= instret + RETIRE_W'(1);
    end
  end

  always_comb begin
    memRead  = (state == S_FETCH) || (state == S_MEM_RD);
    memWrite = (state == S_MEM_WR);
    irWrite  = (state == S_FETCH) && mem_ack;
    pcUpdate = (state == S_EXEC) || (state == S_WB) || ((state == S_MEM_WR) && mem_ack);
    regWrite = ((state == S_EXEC) && (opcode != OP_BRANCH)) || (state == S_WB);
    halted   = (state == S_HALT);
  end

endmodule

// File: tb/tb_control_unit_hs.sv
// Bench for control_unit_hs: vector table, directed corner sequences, randomized run against a phase-level model.
module tb_control_unit_hs;
  localparam int TMO = 4;
  localparam int RW  = 4;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] SYS = 7'b1110011;
  localparam logic [6:0] ILL = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          error, mem_ack, resume;
  logic          pcUpdate, regWrite, memWrite, memRead, irWrite, halted, timeout;
  logic [RW-1:0] instret;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_unit_hs #(.TIMEOUT(TMO), .RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .error(error), .mem_ack(mem_ack),
    .resume(resume), .pcUpdate(pcUpdate), .regWrite(regWrite), .memWrite(memWrite),
    .memRead(memRead), .irWrite(irWrite), .halted(halted), .timeout(timeout),
    .instret(instret)
  );

  // Phase letters: F fetch, D decode, E execute, R read, B writeback, S store, H halt.
  byte ph     = "F";
  int  m_wait = 0;
  bit  m_tmo  = 1'b0;
  int  m_ret  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_alu(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, BR, OPI, 7'b0110011};
  endfunction

  task automatic model_step(input logic [6:0] op, input logic e, input logic a, input logic r);
    byte nx;
    nx = ph;
    if (ph == "H") begin
      if (r && !e) begin
        nx    = "F";
        m_tmo = 1'b0;
      end
    end else if (e) begin
      nx = "H";
    end else begin
      case (ph)
        "F": if (a) nx = "D";
        "D": nx = (op == LD) ? "R" : (op == ST) ? "S" : is_alu(op) ? "E" : "H";
        "E", "B": begin
          nx    = "F";
          m_ret = (m_ret + 1) % (1 << RW);
        end
        "R": if (a) nx = "B";
        "S": if (a) begin
          nx    = "F";
          m_ret = (m_ret + 1) % (1 << RW);
        end
        default: ;
      endcase
      if ((ph inside {"F", "R", "S"}) && !a) begin
        m_wait++;
        if (TMO != 0 && m_wait == TMO) begin
          nx    = "H";
          m_tmo = 1'b1;
        end
      end
    end
    if (nx != ph) m_wait = 0;
    ph = nx;
  endtask

  task automatic set_in(input logic [6:0] op, input logic e, input logic a, input logic r);
    opcode = op; error = e; mem_ack = a; resume = r;
    #1;
  endtask

  task automatic apply(input logic [6:0] op, input logic e, input logic a, input logic r);
    @(negedge clk);
    set_in(op, e, a, r);
  endtask

  task automatic check_model();
    chk("memRead",  memRead,  ph inside {"F", "R"});
    chk("memWrite", memWrite, ph == "S");
    chk("irWrite",  irWrite,  (ph == "F") && mem_ack);
    chk("pcUpdate", pcUpdate, (ph inside {"E", "B"}) || ((ph == "S") && mem_ack));
    chk("regWrite", regWrite, ((ph == "E") && (opcode != BR)) || (ph == "B"));
    chk("halted",   halted,   ph == "H");
    chk("timeout",  timeout,  m_tmo);
    chk("instret",  instret,  m_ret);
  endtask

  task automatic tick();
    model_step(opcode, error, mem_ack, resume);
    @(posedge clk);
  endtask

  task automatic cyc(input logic [6:0] op, input logic e, input logic a, input logic r);
    apply(op, e, a, r);
    check_model();
    tick();
  endtask

  typedef struct {
    logic [6:0] op;
    logic [5:0] exp;  // {memRead, memWrite, irWrite, pcUpdate, regWrite, halted}
    int         ret;
  } vec_t;

  initial begin
    vec_t tbl[13];
    logic [6:0] pick[12];
    tbl[0]  = '{OPI, 6'b101000, 0};
    tbl[1]  = '{OPI, 6'b000000, 0};
    tbl[2]  = '{OPI, 6'b000110, 0};
    tbl[3]  = '{LD,  6'b101000, 1};
    tbl[4]  = '{LD,  6'b000000, 1};
    tbl[5]  = '{LD,  6'b100000, 1};
    tbl[6]  = '{LD,  6'b000110, 1};
    tbl[7]  = '{ST,  6'b101000, 2};
    tbl[8]  = '{ST,  6'b000000, 2};
    tbl[9]  = '{ST,  6'b010100, 2};
    tbl[10] = '{BR,  6'b101000, 3};
    tbl[11] = '{BR,  6'b000000, 3};
    tbl[12] = '{BR,  6'b000100, 3};
    pick = '{LD, ST, OPI, BR, SYS, ILL, 7'b0110111, 7'b0010111, 7'b1101111,
             7'b1100111, 7'b0110011, 7'b0001111};

    rst = 1'b0;
    set_in(7'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_memRead", memRead, 1);
    chk("rst_irWrite", irWrite, 0);
    chk("rst_halted",  halted,  0);
    chk("rst_timeout", timeout, 0);
    chk("rst_instret", instret, 0);
    @(negedge clk);
    rst = 1'b1;

    // Zero-wait program: OP_IMM, LOAD, STORE, BRANCH.
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].op, 1'b0, 1'b1, 1'b0);
      chk("vec_outs", {memRead, memWrite, irWrite, pcUpdate, regWrite, halted}, tbl[i].exp);
      chk("vec_instret", instret, tbl[i].ret);
      tick();
    end

    // Load with three wait cycles in MEM_RD.
    apply(LD, 1'b0, 1'b1, 1'b0);
    chk("prog_retired", instret, 4);
    check_model();
    tick();
    cyc(LD, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(LD, 1'b0, (i == 3), 1'b0);
      chk("rd_hold_memRead", memRead, 1);
      chk("rd_hold_instret", instret, 4);
      check_model();
      tick();
    end
    apply(LD, 1'b0, 1'b1, 1'b0);
    chk("rd_wb_regWrite", regWrite, 1);
    check_model();
    tick();

    // Watchdog in FETCH, then resume.
    for (int i = 0; i < TMO; i++) begin
      apply(OPI, 1'b0, 1'b0, 1'b0);
      if (i == 0) chk("rd_retired_once", instret, 5);
      chk("to_wait_halted", halted, 0);
      check_model();
      tick();
    end
    apply(OPI, 1'b0, 1'b0, 1'b0);
    chk("to_halted", halted, 1);
    chk("to_flag", timeout, 1);
    chk("to_memRead", memRead, 0);
    check_model();
    tick();
    cyc(OPI, 1'b0, 1'b0, 1'b1);
    apply(OPI, 1'b0, 1'b0, 1'b0);
    chk("res_halted", halted, 0);
    chk("res_flag", timeout, 0);
    chk("res_instret", instret, 5);
    check_model();
    tick();

    // Illegal opcode and SYSTEM both halt from DECODE.
    for (int k = 0; k < 2; k++) begin
      cyc(OPI, 1'b0, 1'b1, 1'b0);
      apply(k == 0 ? ILL : SYS, 1'b0, 1'b1, 1'b0);
      chk("dec_regWrite", regWrite, 0);
      chk("dec_pcUpdate", pcUpdate, 0);
      tick();
      apply(OPI, 1'b0, 1'b0, 1'b0);
      chk("dec_halted", halted, 1);
      chk("dec_instret", instret, 5);
      check_model();
      tick();
      cyc(OPI, 1'b0, 1'b0, 1'b1);
    end

    // Error alongside mem_ack in MEM_WR.
    cyc(ST, 1'b0, 1'b1, 1'b0);
    cyc(ST, 1'b0, 1'b1, 1'b0);
    apply(ST, 1'b1, 1'b1, 1'b0);
    chk("err_memWrite", memWrite, 1);
    check_model();
    tick();
    apply(ST, 1'b1, 1'b0, 1'b1);
    chk("err_halted", halted, 1);
    chk("err_instret", instret, 5);
    check_model();
    tick();
    apply(ST, 1'b0, 1'b0, 1'b1);
    chk("err_res_blocked", halted, 1);
    check_model();
    tick();
    apply(ST, 1'b0, 1'b0, 1'b0);
    chk("err_res_fetch", memRead, 1);
    check_model();
    tick();

    // Sixteen ALU retires wrap the 4-bit counter through 15->0.
    for (int i = 0; i < 16; i++) begin
      apply(OPI, 1'b0, 1'b1, 1'b0);
      chk("wrap_instret", instret, (5 + i) % 16);
      check_model();
      tick();
      cyc(OPI, 1'b0, 1'b1, 1'b0);
      cyc(OPI, 1'b0, 1'b1, 1'b0);
    end
    apply(OPI, 1'b0, 1'b1, 1'b0);
    chk("wrap_final", instret, 5);
    check_model();
    tick();

    // Async reset between edges while in MEM_RD.
    cyc(LD, 1'b0, 1'b1, 1'b0);
    apply(LD, 1'b0, 1'b0, 1'b0);
    check_model();
    chk("pre_rst_irWrite", irWrite, 0);
    #1 rst = 1'b0;
    #1;
    chk("arst_memRead", memRead, 1);
    chk("arst_instret", instret, 0);
    chk("arst_halted",  halted,  0);
    mem_ack = 1'b1;
    #1;
    chk("arst_fetch_irWrite", irWrite, 1);
    ph = "F"; m_wait = 0; m_tmo = 1'b0; m_ret = 0;
    @(negedge clk);
    rst = 1'b1;
    set_in(OPI, 1'b0, 1'b0, 1'b0);
    check_model();
    tick();

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      logic e, a, r;
      e = ($urandom_range(0, 99) < 3);
      a = ($urandom_range(0, 99) < 65);
      r = ($urandom_range(0, 99) < ((ph == "H") ? 40 : 10));
      cyc(pick[$urandom_range(0, 11)], e, a, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
